// File: rtl/rr_grant_sched.sv
// rr_grant_sched: round-robin scheduler sharing one resource among 8 requesters.
// Issues a registered one-hot grant, its binary index and a valid flag. Every
// release (or revoke) is followed by exactly one idle cycle before the next
// grant, so the one-hot select lines always break before they make.
//
// Optional build macro HOLD_LIMIT_EN: when defined, a grant held for MAX_HOLD
// cycles is forcibly revoked and preempt pulses for one cycle. When undefined,
// grants are held indefinitely and preempt is tied low.
module rr_grant_sched #(
    parameter int unsigned N_REQ    = 8,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] gnt_idx,
    output logic                     gnt_valid,
    output logic                     preempt
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    typedef enum logic [0:0] {StIdle, StGrant} state_t;

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   sel;
    logic [IDX_W-1:0]   cand;
    logic               found;
    logic [N_REQ-1:0]   sel_onehot;

`ifdef HOLD_LIMIT_EN
    localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);
    logic [HOLD_W-1:0] hold_cnt;
`else
    logic unused_hold;
    assign unused_hold = ^MAX_HOLD;
    assign preempt     = 1'b0;
`endif

    // Pick the first requester at or after ptr, wrapping past the top index.
    always_comb begin
        sel        = ptr;
        cand       = '0;
        found      = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = ptr + IDX_W'(i);
            if (!found && req[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
        sel_onehot      = '0;
        sel_onehot[sel] = 1'b1;
    end

    // Grant FSM; all outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            ptr       <= '0;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
`ifdef HOLD_LIMIT_EN
            preempt   <= 1'b0;
            hold_cnt  <= '0;
`endif
        end else begin
            case (state)
                StIdle: begin
`ifdef HOLD_LIMIT_EN
                    preempt <= 1'b0;
`endif
                    if (|req) begin
                        gnt       <= sel_onehot;
                        gnt_idx   <= sel;
                        gnt_valid <= 1'b1;
                        state     <= StGrant;
`ifdef HOLD_LIMIT_EN
                        hold_cnt  <= '0;
`endif
                    end
                end
                StGrant: begin
                    if (!req[gnt_idx]) begin
                        // Normal release; gnt_idx is kept for debug.
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                        ptr       <= gnt_idx + IDX_W'(1);
                        state     <= StIdle;
`ifdef HOLD_LIMIT_EN
                    end else if (hold_cnt == HOLD_W'(MAX_HOLD - 1)) begin
                        // Holder hit the limit: revoke exactly like a release.
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                        ptr       <= gnt_idx + IDX_W'(1);
                        preempt   <= 1'b1;
                        state     <= StIdle;
                    end else begin
                        hold_cnt  <= hold_cnt + HOLD_W'(1);
`endif
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_grant_sched.sv
// Scoreboard bench for rr_grant_sched: the driver runs a behavioural model and
// queues the expected outputs for each edge; a monitor pops and compares.
module tb_rr_grant_sched;

    localparam int MAX_HOLD = 16;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       preempt;

    rr_grant_sched dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
        logic       pre;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference model state (spec-level: owner, pointer, hold age)
    bit m_busy;
    int m_idx;
    int m_ptr;
    int m_hold;
    bit m_pre;

    task automatic model_step(input logic [7:0] r, input logic rs);
        if (rs) begin
            m_busy = 0; m_idx = 0; m_ptr = 0; m_pre = 0; m_hold = 0;
        end else if (!m_busy) begin
            m_pre = 0;
            for (int k = 0; k < 8; k++) begin
                int c;
                c = (m_ptr + k) % 8;
                if (r[c]) begin
                    m_busy = 1; m_idx = c; m_hold = 0;
                    break;
                end
            end
        end else if (!r[m_idx]) begin
            m_busy = 0;
            m_ptr  = (m_idx + 1) % 8;
        end else begin
`ifdef HOLD_LIMIT_EN
            if (m_hold + 1 == MAX_HOLD) begin
                m_busy = 0; m_ptr = (m_idx + 1) % 8; m_pre = 1;
            end else begin
                m_hold++;
            end
`endif
        end
    endtask

    task automatic drive(input logic [7:0] r, input logic rs);
        exp_t e;
        @(negedge clk);
        req = r;
        rst = rs;
        model_step(r, rs);
        e.gnt   = m_busy ? (8'h01 << m_idx) : 8'h00;
        e.idx   = 3'(m_idx);
        e.valid = m_busy;
        e.pre   = m_pre;
        exp_q.push_back(e);
    endtask

    // Monitor: compare after each active edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (gnt !== e.gnt) begin
                    errors++;
                    $display("FAIL gnt cyc=%0d got=%h exp=%h", cyc, gnt, e.gnt);
                end
                checks++;
                if (gnt_valid !== e.valid) begin
                    errors++;
                    $display("FAIL gnt_valid cyc=%0d got=%b exp=%b", cyc, gnt_valid, e.valid);
                end
                checks++;
                if (gnt_idx !== e.idx) begin
                    errors++;
                    $display("FAIL gnt_idx cyc=%0d got=%0d exp=%0d", cyc, gnt_idx, e.idx);
                end
                checks++;
                if (preempt !== e.pre) begin
                    errors++;
                    $display("FAIL preempt cyc=%0d got=%b exp=%b", cyc, preempt, e.pre);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] r;
        int         age;
        int         order[$];
        bit         was_busy;

        req = 8'h00;
        rst = 1'b1;

        // Reset with all requests high
        drive(8'hFF, 1'b1);
        drive(8'hFF, 1'b1);

        // Round-robin sweep: each grantee drops its bit 3 cycles in
        r = 8'hFF; age = 0; was_busy = 0;
        for (int c = 0; c < 60 && (r != 8'h00 || m_busy); c++) begin
            drive(r, 1'b0);
            if (m_busy && !was_busy) order.push_back(m_idx);
            was_busy = m_busy;
            age = m_busy ? age + 1 : 0;
            if (age == 3) r[m_idx] = 1'b0;
        end
        checks++;
        if (order.size() != 8) begin
            errors++;
            $display("FAIL rr_count got=%0d exp=8", order.size());
        end
        for (int k = 0; k < order.size() && k < 8; k++) begin
            checks++;
            if (order[k] != k) begin
                errors++;
                $display("FAIL rr_order slot=%0d got=%0d exp=%0d", k, order[k], k);
            end
        end

        // Single requester held 5 cycles
        repeat (5) drive(8'h10, 1'b0);
        repeat (3) drive(8'h00, 1'b0);

        // Wrap-around: grant 6, release, then 0x41 -> 0, release 0 -> 6
        repeat (3) drive(8'h40, 1'b0);
        drive(8'h00, 1'b0);
        repeat (3) drive(8'h41, 1'b0);
        repeat (4) drive(8'h40, 1'b0);
        repeat (2) drive(8'h00, 1'b0);

        // Mid-grant reset, then 0x88 -> grant 3
        repeat (3) drive(8'h08, 1'b0);
        drive(8'h08, 1'b1);
        repeat (4) drive(8'h88, 1'b0);
        repeat (2) drive(8'h00, 1'b0);

        // Randomized traffic with sticky request bits and rare resets
        r = 8'h00;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 8; b++)
                if ($urandom_range(7) == 0) r[b] = ~r[b];
            drive(r, ($urandom_range(127) == 0));
        end
        drive(8'h00, 1'b0);

        // Drain the scoreboard
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d exp=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
